// File: rtl/shift_seq_pkg.sv
// Shared mode and state encodings for the iterative/barrel shifter.
package shift_seq_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_seq_step.sv
// Combinational one-position shift step: next value plus the bit that falls out.
module shift_seq_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  always_comb begin
    next_value = value;
    out_bit    = value[0];
    case (mode)
      MODE_LSL: begin
        next_value = {value[WIDTH-2:0], fill};
        out_bit    = value[WIDTH-1];
      end
      MODE_LSR: next_value = {fill, value[WIDTH-1:1]};
      MODE_ASR: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
      default:  next_value = {value[0], value[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_seq_n.sv
// Multi-cycle shifter with start/ready/done handshake and bit-bucket output.
// Define SHIFT_SEQ_BARREL_EN for a fixed-latency barrel SHIFT stage.
module shift_seq_n
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data,
  input  logic               shift_in_left,
  input  logic               shift_in_right,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               bb_out
);

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               sil_q, sil_d, sir_q, sir_d;
  logic [WIDTH-1:0]   result_d;
  logic               bb_d;
  logic               fill;
  logic [WIDTH-1:0]   step_val;
  logic               step_out;

  assign fill = (mode_q == MODE_LSL) ? sir_q : sil_q;

`ifdef SHIFT_SEQ_BARREL_EN
  localparam int unsigned NSTAGE = (32'd1 << SHAMT_W) - 32'd1;

  logic             stepped_q, stepped_d;
  logic [WIDTH-1:0] vals [0:NSTAGE];
  logic             outs [0:NSTAGE];

  // One stage per possible amount, so over-range shifts keep exact fill/wrap semantics.
  assign vals[0] = result;
  assign outs[0] = 1'b0;
  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    shift_seq_step #(.WIDTH(WIDTH)) u_step (
      .value      (vals[k-1]),
      .mode       (mode_q),
      .fill       (fill),
      .next_value (vals[k]),
      .out_bit    (outs[k])
    );
  end
  assign step_val = vals[cnt_q];
  assign step_out = outs[cnt_q];
`else
  shift_seq_step #(.WIDTH(WIDTH)) u_step (
    .value      (result),
    .mode       (mode_q),
    .fill       (fill),
    .next_value (step_val),
    .out_bit    (step_out)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
`ifdef SHIFT_SEQ_BARREL_EN
      ST_SHIFT: if (stepped_q) state_d = ST_DONE;
`else
      ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; operands are only captured on an accepted start.
  always_comb begin
    result_d = result;
    bb_d     = bb_out;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    sil_d    = sil_q;
    sir_d    = sir_q;
`ifdef SHIFT_SEQ_BARREL_EN
    stepped_d = stepped_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        result_d = data;
        bb_d     = 1'b0;
        cnt_d    = shamt;
        mode_d   = mode;
        sil_d    = shift_in_left;
        sir_d    = shift_in_right;
`ifdef SHIFT_SEQ_BARREL_EN
        stepped_d = 1'b0;
`endif
      end
`ifdef SHIFT_SEQ_BARREL_EN
      ST_SHIFT: if (!stepped_q) begin
        result_d  = step_val;
        bb_d      = step_out;
        stepped_d = 1'b1;
      end
`else
      ST_SHIFT: if (cnt_q != '0) begin
        result_d = step_val;
        bb_d     = step_out;
        cnt_d    = cnt_q - SHAMT_W'(1);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      bb_out <= 1'b0;
      cnt_q  <= '0;
      mode_q <= MODE_LSL;
      sil_q  <= 1'b0;
      sir_q  <= 1'b0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SHIFT_SEQ_BARREL_EN
      stepped_q <= 1'b0;
`endif
    end else begin
      result <= result_d;
      bb_out <= bb_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      sil_q  <= sil_d;
      sir_q  <= sir_d;
      ready  <= (state_d == ST_IDLE);
      busy   <= (state_d == ST_SHIFT);
      done   <= (state_d == ST_DONE);
`ifdef SHIFT_SEQ_BARREL_EN
      stepped_q <= stepped_d;
`endif
    end
  end

endmodule
